// File: rtl/manchester_pkg.sv
// Shared definitions for the Manchester frame transmitter and the matching detector bench.
// Contents:
//   state_t / St*   transmitter FSM state encoding (legacy-compatible constants)
//   DefaultLimit    detector run-length constant
//   *_len()         header/gap/tail durations in clk cycles, derived from LIMIT
package manchester_pkg;

    localparam int unsigned DefaultLimit = 14;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StGap   = 3'd1;
    localparam state_t StHdrHi = 3'd2;
    localparam state_t StHdrLo = 3'd3;
    localparam state_t StMark  = 3'd4;
    localparam state_t StData  = 3'd5;
    localparam state_t StTail  = 3'd6;

    // Low gap before every frame; long enough to clear the detector's run counter.
    function automatic int unsigned gap_len(input int unsigned limit);
        return limit + 2;
    endfunction

    // High run of a first-frame header; the detector counts limit+5 at its falling edge.
    function automatic int unsigned hdr_first_len(input int unsigned limit);
        return limit + 6;
    endfunction

    // High run of a continuation header; the detector counts exactly limit.
    function automatic int unsigned hdr_cont_hi_len(input int unsigned limit);
        return limit + 1;
    endfunction

    // Low run following the continuation high run.
    function automatic int unsigned hdr_cont_lo_len(input int unsigned limit);
        return limit - 9;
    endfunction

    // Low tail after the payload.
    function automatic int unsigned tail_len(input int unsigned limit);
        return limit + 2;
    endfunction

endpackage

// File: rtl/manchester_tx_if.sv
// Transmit request/status bundle between packet logic (master) and manchester_tx (slave).
// Signals:
//   tx_start  master->slave  request, honoured only while tx_ready=1
//   tx_first  master->slave  1 = first-frame header, 0 = continuation header
//   tx_data   master->slave  payload word, latched at acceptance
//   tx_ready  slave->master  transmitter idle
//   tx_busy   slave->master  frame in progress
//   tx_done   slave->master  one-cycle pulse on the last tail cycle
//   man_out   slave->line    registered Manchester line level
interface manchester_tx_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic              tx_start;
    logic              tx_first;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx_busy;
    logic              tx_done;
    logic              man_out;

    modport master (
        output tx_start, tx_first, tx_data,
        input  tx_ready, tx_busy, tx_done, man_out
    );

    modport slave (
        input  tx_start, tx_first, tx_data,
        output tx_ready, tx_busy, tx_done, man_out
    );
endinterface

// File: rtl/manchester_tx_timer.sv
// Loadable run-length down-counter used to time every transmitter state.
// Ports:
//   clk, rst   clock and synchronous active-high reset (count -> 0)
//   i_load     load i_value this edge (takes priority over counting)
//   i_value    duration-1 of the run being started
//   o_count    current count
//   o_zero     count has reached 0; holds there (no wrap)
module manchester_tx_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/manchester_tx.sv
// Manchester frame transmitter.
// Frame: low gap, sync header (first-frame or continuation), marker half-bit, DATA_W
// Manchester bits MSB first (1 = low/high, 0 = high/low), low tail.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        manchester_tx_if slave: tx_start/tx_first/tx_data in,
//              tx_ready/tx_busy/tx_done/man_out out (all outputs registered)
module manchester_tx
    import manchester_pkg::*;
#(
    parameter int unsigned LIMIT    = DefaultLimit,
    parameter int unsigned HALF_BIT = 4,
    parameter int unsigned DATA_W   = 8
) (
    input logic              clk,
    input logic              rst,
    manchester_tx_if.slave   bus
);
    localparam int unsigned CntW = $clog2(LIMIT + 7);
    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CntW-1:0] GapLoad    = CntW'(gap_len(LIMIT) - 1);
    localparam logic [CntW-1:0] HdrFLoad   = CntW'(hdr_first_len(LIMIT) - 1);
    localparam logic [CntW-1:0] HdrCHiLoad = CntW'(hdr_cont_hi_len(LIMIT) - 1);
    localparam logic [CntW-1:0] HdrCLoLoad = CntW'(hdr_cont_lo_len(LIMIT) - 1);
    localparam logic [CntW-1:0] HalfLoad   = CntW'(HALF_BIT - 1);
    localparam logic [CntW-1:0] TailLoad   = CntW'(tail_len(LIMIT) - 1);
    localparam logic [BitW-1:0] LastBit    = BitW'(DATA_W - 1);

    state_t            r_state;
    logic              r_first;
    logic              r_half;
    logic [BitW-1:0]   r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_man;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;

    state_t            w_state_nxt;
    logic              w_first_nxt;
    logic              w_half_nxt;
    logic [BitW-1:0]   w_bit_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_man_nxt;
    logic              w_done_nxt;
    logic              w_load;
    logic [CntW-1:0]   w_load_val;
    logic [CntW-1:0]   w_count;
    logic              w_zero;

    manchester_tx_timer #(
        .WIDTH(CntW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_value(w_load_val),
        .o_count(w_count),
        .o_zero (w_zero)
    );

    // Every transition reloads the timer and sets the line level of the state being entered,
    // so man_out is registered together with the state.
    always_comb begin
        w_state_nxt = r_state;
        w_first_nxt = r_first;
        w_half_nxt  = r_half;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_man_nxt   = r_man;
        w_load      = 1'b0;
        w_load_val  = '0;

        unique case (r_state)
            StIdle: begin
                w_man_nxt = 1'b0;
                if (bus.tx_start) begin
                    w_state_nxt = StGap;
                    w_first_nxt = bus.tx_first;
                    w_shift_nxt = bus.tx_data;
                    w_load      = 1'b1;
                    w_load_val  = GapLoad;
                end
            end
            StGap: begin
                if (w_zero) begin
                    w_state_nxt = StHdrHi;
                    w_man_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = r_first ? HdrFLoad : HdrCHiLoad;
                end
            end
            StHdrHi: begin
                if (w_zero) begin
                    w_state_nxt = r_first ? StMark : StHdrLo;
                    w_man_nxt   = 1'b0;
                    w_load      = 1'b1;
                    w_load_val  = r_first ? HalfLoad : HdrCLoLoad;
                end
            end
            StHdrLo: begin
                if (w_zero) begin
                    w_state_nxt = StMark;
                    w_man_nxt   = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = HalfLoad;
                end
            end
            StMark: begin
                if (w_zero) begin
                    w_state_nxt = StData;
                    w_half_nxt  = 1'b0;
                    w_bit_nxt   = '0;
                    w_man_nxt   = ~r_shift[DATA_W-1];
                    w_load      = 1'b1;
                    w_load_val  = HalfLoad;
                end
            end
            StData: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = HalfLoad;
                    if (!r_half) begin
                        // Second half carries the true bit value.
                        w_half_nxt = 1'b1;
                        w_man_nxt  = r_shift[DATA_W-1];
                    end else begin
                        w_shift_nxt = r_shift << 1;
                        w_half_nxt  = 1'b0;
                        if (r_bit == LastBit) begin
                            w_state_nxt = StTail;
                            w_man_nxt   = 1'b0;
                            w_load_val  = TailLoad;
                        end else begin
                            w_bit_nxt = r_bit + BitW'(1);
                            w_man_nxt = ~w_shift_nxt[DATA_W-1];
                        end
                    end
                end
            end
            StTail: begin
                if (w_zero) begin
                    w_state_nxt = StIdle;
                    w_man_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_man_nxt   = 1'b0;
            end
        endcase
    end

    // The timer steps 1 -> 0 on the same edge that starts the last tail cycle.
    assign w_done_nxt = (r_state == StTail) && (w_count == CntW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_first <= 1'b0;
            r_half  <= 1'b0;
            r_bit   <= '0;
            r_shift <= '0;
            r_man   <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_first <= w_first_nxt;
            r_half  <= w_half_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_man   <= w_man_nxt;
            r_ready <= (w_state_nxt == StIdle);
            r_busy  <= (w_state_nxt != StIdle);
            r_done  <= w_done_nxt;
        end
    end

    assign bus.man_out  = r_man;
    assign bus.tx_ready = r_ready;
    assign bus.tx_busy  = r_busy;
    assign bus.tx_done  = r_done;
endmodule

// File: tb/tb_manchester_tx.sv
// Directed self-checking bench for manchester_tx (LIMIT=14, HALF_BIT=4, DATA_W=8).
// Waveforms are captured one bit per cycle after acceptance (bit i = cycle i+1).
module tb_manchester_tx;
    localparam int FrameLen = 120;

    logic clk;
    logic rst;

    int n_checks;
    int n_pass;

    logic [127:0] exp_w;
    int           exp_n;

    manchester_tx_if #(.DATA_W(8)) bus ();

    manchester_tx #(
        .LIMIT   (14),
        .HALF_BIT(4),
        .DATA_W  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic add_run(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            exp_w[exp_n] = lvl;
            exp_n++;
        end
    endtask

    // Hand-listed run lengths for the default parameters.
    task automatic build(input logic first, input logic [7:0] data);
        exp_w = '0;
        exp_n = 0;
        add_run(1'b0, 16);
        if (first) begin
            add_run(1'b1, 20);
            add_run(1'b0, 4);
        end else begin
            add_run(1'b1, 15);
            add_run(1'b0, 5);
            add_run(1'b1, 4);
        end
        for (int b = 7; b >= 0; b--) begin
            add_run(~data[b], 4);
            add_run(data[b], 4);
        end
        add_run(1'b0, 16);
    endtask

    // Longest constant run inside the data section (cycles 41..104).
    function automatic int max_run(input logic [127:0] w);
        int best = 0;
        int cur  = 0;
        for (int i = 40; i < 104; i++) begin
            if (i > 40 && w[i] == w[i-1]) cur++;
            else cur = 1;
            if (cur > best) best = cur;
        end
        return best;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle afterwards.
    task automatic send(input logic first, input logic [7:0] data, input bit pulse,
                        output logic [127:0] wave, output logic [127:0] done_v,
                        output logic [127:0] busy_v, output logic [127:0] ready_v);
        check("ready_before_start", {127'b0, bus.tx_ready}, 128'd1);
        bus.tx_start = 1'b1;
        bus.tx_first = first;
        bus.tx_data  = data;
        @(negedge clk);
        bus.tx_start = 1'b0;
        bus.tx_first = ~first;
        bus.tx_data  = ~data;
        wave    = '0;
        done_v  = '0;
        busy_v  = '0;
        ready_v = '0;
        for (int i = 0; i < FrameLen; i++) begin
            wave[i]    = bus.man_out;
            done_v[i]  = bus.tx_done;
            busy_v[i]  = bus.tx_busy;
            ready_v[i] = bus.tx_ready;
            bus.tx_start = pulse && (i == 4 || i == 29 || i == 118);
            @(negedge clk);
        end
        bus.tx_start = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic first, input logic [7:0] data,
                               input logic [127:0] wave, input logic [127:0] done_v,
                               input logic [127:0] busy_v, input logic [127:0] ready_v);
        build(first, data);
        check({tag, "_wave"}, wave, exp_w);
        check({tag, "_done"}, done_v, 128'd1 << 119);
        check({tag, "_busy"}, busy_v, {8'b0, {120{1'b1}}});
        check({tag, "_ready"}, ready_v, 128'd0);
        check({tag, "_idle_after"}, {124'b0, bus.man_out, bus.tx_ready, bus.tx_busy,
              bus.tx_done}, 128'b0100);
    endtask

    initial begin
        logic [127:0] w, d, b, r;
        logic         seen_done;
        n_checks     = 0;
        n_pass       = 0;
        rst          = 1'b1;
        bus.tx_start = 1'b0;
        bus.tx_first = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            check("reset_idle", {124'b0, bus.man_out, bus.tx_ready, bus.tx_busy, bus.tx_done},
                  128'b0100);
            @(negedge clk);
        end

        send(1'b1, 8'hA5, 1'b0, w, d, b, r);
        check_frame("first_a5", 1'b1, 8'hA5, w, d, b, r);
        check("first_a5_maxrun", 128'(max_run(w)), 128'd8);

        send(1'b0, 8'h00, 1'b0, w, d, b, r);
        check_frame("cont_00", 1'b0, 8'h00, w, d, b, r);
        check("cont_00_maxrun", 128'(max_run(w)), 128'd4);

        repeat (3) @(negedge clk);

        // Starts while busy are ignored; next frame starts in the first IDLE cycle.
        send(1'b1, 8'h3C, 1'b1, w, d, b, r);
        check_frame("busy_ignore_3c", 1'b1, 8'h3C, w, d, b, r);
        send(1'b0, 8'hC3, 1'b0, w, d, b, r);
        check_frame("back_to_back_c3", 1'b0, 8'hC3, w, d, b, r);

        send(1'b1, 8'hFF, 1'b0, w, d, b, r);
        check_frame("first_ff", 1'b1, 8'hFF, w, d, b, r);
        check("first_ff_maxrun", 128'(max_run(w)), 128'd4);

        // Reset during data bit 3 (cycles 65..72).
        bus.tx_start = 1'b1;
        bus.tx_first = 1'b1;
        bus.tx_data  = 8'hA5;
        @(negedge clk);
        bus.tx_start = 1'b0;
        repeat (64) @(negedge clk);
        check("mid_frame_busy", {127'b0, bus.tx_busy}, 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", {124'b0, bus.man_out, bus.tx_ready, bus.tx_busy, bus.tx_done},
              128'b0100);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 70; i++) begin
            seen_done = seen_done | bus.tx_done | bus.man_out;
            @(negedge clk);
        end
        check("after_reset_quiet", {127'b0, seen_done}, 128'd0);

        send(1'b0, 8'h5A, 1'b0, w, d, b, r);
        check_frame("recover_5a", 1'b0, 8'h5A, w, d, b, r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
